table_memory: RTL and testbench
===============================

TABLE_MEMORY -- requirements
Module: table_memory

Interface
REQ-001 Parameter COLS, default 18, cells per row.
REQ-002 Parameter ROWS, default 8, rows on table.
REQ-003 Parameter CARD_W, default 6, card code width.
REQ-004 Parameter EMPTY, default 54, code marking an empty cell.
REQ-005 Parameter LEN_W, default 3, width of shift length; XW=clog2(COLS), YW=clog2(ROWS), CW=clog2(ROWS*COLS+1).
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  block can accept command.
REQ-010 cmd_op  in  3  0 PLACE, 1 REMOVE, 2 SHIFT, 3 COMMIT, 4 RESTORE; 5-7 illegal.
REQ-011 cmd_x  in  XW  column; cmd_y  in  YW  row.
REQ-012 cmd_card  in  CARD_W  card for PLACE.
REQ-013 cmd_len  in  LEN_W  SHIFT run length; cmd_dir  in  1  SHIFT direction, 0 left, 1 right.
REQ-014 map  out  ROWS*COLS*CARD_W  live table; cell p=y*COLS+x at bits [p*CARD_W +: CARD_W].
REQ-015 occ_cnt  out  CW  number of non-EMPTY cells in map.
REQ-016 dirty  out  1  map differs in content from snapshot since last COMMIT/RESTORE.
REQ-017 done  out  1  one-cycle pulse when a command completes; err  out  1  valid with done.
REQ-018 rd_card  out  CARD_W  card removed by last successful REMOVE, held until next REMOVE.

Function
REQ-019 Command accepted on a cycle where cmd_valid&&cmd_ready; cmd_* sampled only then.
REQ-020 FSM states IDLE, SHIFT, FIN; cmd_ready=1 only in IDLE.
REQ-021 PLACE/REMOVE/COMMIT/RESTORE/illegal: IDLE->FIN on accept, FIN->IDLE next cycle; done=1 in FIN (latency 1 cycle from accept).
REQ-022 Any command with cmd_x>=COLS or cmd_y>=ROWS, or illegal op: no state change, err=1.
REQ-023 PLACE: target EMPTY -> write cmd_card, occ_cnt+1, dirty=1; target occupied or cmd_card==EMPTY -> no write, err=1.
REQ-024 REMOVE: target occupied -> write EMPTY, rd_card=old value, occ_cnt-1, dirty=1; target EMPTY -> err=1, rd_card unchanged.
REQ-025 SHIFT legality (checked at accept): cmd_len>=1; right: x+len<COLS and cell x+len EMPTY; left: x>=1 and cell x-1 EMPTY; else IDLE->FIN with err=1, map unchanged.
REQ-026 Legal SHIFT: IDLE->SHIFT; moves one cell per cycle starting at far end in move direction (right: x+len-1 down to x; left: x up to x+len-1); final step also writes vacated cell (x for right, x+len-1 for left) EMPTY; after len cycles ->FIN; done at accept+len+1.
REQ-027 SHIFT never crosses row boundary; occ_cnt unchanged; dirty=1.
REQ-028 COMMIT: snapshot<=map, snap_cnt<=occ_cnt, dirty=0, single cycle.
REQ-029 RESTORE: map<=snapshot, occ_cnt<=snap_cnt, dirty=0, single cycle.
REQ-030 map writes occur only in SHIFT state or on the accept edge; cmd_valid while busy ignored (not queued).
REQ-031 Counter arithmetic exact to CW bits; no wrap possible given PLACE/REMOVE checks.
REQ-032 err=0 whenever done=0.

Reset
REQ-033 rst has priority over all activity including mid-SHIFT; next edge: state IDLE, every map and snapshot cell EMPTY, occ_cnt=0, snap_cnt=0, dirty=0, done=0, err=0, rd_card=EMPTY.
REQ-034 cmd_ready=1 on the first cycle after rst deasserts.

Verification
REQ-035 PLACE card 5 at (3,1), default params -> map bits[(21)*6 +:6]=5, occ_cnt=1, done one cycle after accept, err=0; repeat same cell -> err=1, map unchanged.
REQ-036 Cells (4..6,0)=10,11,12, SHIFT x=4 len=3 dir=1 -> cells 5..7=10,11,12, cell 4=EMPTY, done at accept+4, cmd_ready low 4 cycles.
REQ-037 SHIFT x=15 len=3 dir=1 -> err=1, map unchanged; SHIFT x=0 dir=0 -> err=1.
REQ-038 COMMIT with 3 cards, PLACE 2 more, REMOVE 1 -> occ_cnt=4, dirty=1; RESTORE -> map equals committed image, occ_cnt=3, dirty=0.
REQ-039 Assert rst during second SHIFT step -> next cycle all cells EMPTY, occ_cnt=0, IDLE, no done pulse.
REQ-040 Rerun REQ-035/036 with COLS=13, ROWS=4 -> cell index y*13+x, shift bounded at column 12.

Source files
------------

// File: rtl/table_memory.sv
// Card table of ROWS x COLS cells holding CARD_W-bit codes: place/remove single cells,
// shift a run of cells within a row one cell per cycle, and commit/restore one snapshot.
module table_memory #(
   parameter int COLS   = 18,
   parameter int ROWS   = 8,
   parameter int CARD_W = 6,
   parameter int EMPTY  = 54,
   parameter int LEN_W  = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [2:0]                         cmd_op,
   input  logic [$clog2(COLS)-1:0]            cmd_x,
   input  logic [$clog2(ROWS)-1:0]            cmd_y,
   input  logic [CARD_W-1:0]                  cmd_card,
   input  logic [LEN_W-1:0]                   cmd_len,
   input  logic                               cmd_dir,
   output logic [ROWS*COLS*CARD_W-1:0]        map,
   output logic [$clog2(ROWS*COLS+1)-1:0]     occ_cnt,
   output logic                               dirty,
   output logic                               done,
   output logic                               err,
   output logic [CARD_W-1:0]                  rd_card
);

   localparam int XW = $clog2(COLS);
   localparam int CW = $clog2(ROWS*COLS+1);
   localparam int N  = ROWS*COLS;
   localparam int SW = XW + LEN_W + 1;
   localparam logic [CARD_W-1:0] EMPTY_C = CARD_W'(EMPTY);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FIN} state_t;

   localparam logic [2:0] OP_PLACE   = 3'd0;
   localparam logic [2:0] OP_REMOVE  = 3'd1;
   localparam logic [2:0] OP_SHIFT   = 3'd2;
   localparam logic [2:0] OP_COMMIT  = 3'd3;
   localparam logic [2:0] OP_RESTORE = 3'd4;

   state_t              state_q, state_d;
   logic [CARD_W-1:0]   map_q  [N];
   logic [CARD_W-1:0]   map_d  [N];
   logic [CARD_W-1:0]   snap_q [N];
   logic [CARD_W-1:0]   snap_d [N];
   logic [CW-1:0]       occ_q, occ_d;
   logic [CW-1:0]       snap_cnt_q, snap_cnt_d;
   logic                dirty_q, dirty_d;
   logic                err_q, err_d;
   logic [CARD_W-1:0]   rd_card_q, rd_card_d;
   logic [CW-1:0]       sh_pos_q, sh_pos_d;
   logic [LEN_W-1:0]    sh_cnt_q, sh_cnt_d;
   logic                sh_dir_q, sh_dir_d;

   logic                in_range;
   logic [CW-1:0]       cmd_p, last_p, tgt_r_p, tgt_l_p, step_dst;
   logic [SW-1:0]       run_end;
   logic [CARD_W-1:0]   cmd_cell;
   logic                shift_ok;

   // Command decode; cell indices are only meaningful when in_range is set.
   always_comb begin
      in_range = (32'(cmd_x) < COLS) && (32'(cmd_y) < ROWS);
      cmd_p    = CW'(cmd_y) * CW'(COLS) + CW'(cmd_x);
      run_end  = SW'(cmd_x) + SW'(cmd_len);
      last_p   = cmd_p + CW'(cmd_len) - CW'(1);
      tgt_r_p  = cmd_p + CW'(cmd_len);
      tgt_l_p  = cmd_p - CW'(1);
      cmd_cell = in_range ? map_q[cmd_p] : EMPTY_C;
      shift_ok = 1'b0;
      if (in_range && (cmd_len != '0)) begin
         if (cmd_dir) begin
            shift_ok = (run_end < SW'(COLS)) && (map_q[tgt_r_p] == EMPTY_C);
         end else begin
            shift_ok = (cmd_x != '0) && (run_end <= SW'(COLS)) && (map_q[tgt_l_p] == EMPTY_C);
         end
      end
      step_dst = sh_dir_q ? sh_pos_q + CW'(1) : sh_pos_q - CW'(1);
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      map_d      = map_q;
      snap_d     = snap_q;
      occ_d      = occ_q;
      snap_cnt_d = snap_cnt_q;
      dirty_d    = dirty_q;
      err_d      = err_q;
      rd_card_d  = rd_card_q;
      sh_pos_d   = sh_pos_q;
      sh_cnt_d   = sh_cnt_q;
      sh_dir_d   = sh_dir_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_FIN;
               err_d   = 1'b0;
               if (!in_range) begin
                  err_d = 1'b1;
               end else begin
                  case (cmd_op)
                     OP_PLACE: begin
                        if ((cmd_cell == EMPTY_C) && (cmd_card != EMPTY_C)) begin
                           map_d[cmd_p] = cmd_card;
                           occ_d        = occ_q + CW'(1);
                           dirty_d      = 1'b1;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     OP_REMOVE: begin
                        if (cmd_cell != EMPTY_C) begin
                           map_d[cmd_p] = EMPTY_C;
                           rd_card_d    = cmd_cell;
                           occ_d        = occ_q - CW'(1);
                           dirty_d      = 1'b1;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     OP_SHIFT: begin
                        if (shift_ok) begin
                           // Start at the far end so no card is overwritten before it moves.
                           state_d  = ST_SHIFT;
                           sh_pos_d = cmd_dir ? last_p : cmd_p;
                           sh_cnt_d = cmd_len;
                           sh_dir_d = cmd_dir;
                           dirty_d  = 1'b1;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     OP_COMMIT: begin
                        snap_d     = map_q;
                        snap_cnt_d = occ_q;
                        dirty_d    = 1'b0;
                     end
                     OP_RESTORE: begin
                        map_d   = snap_q;
                        occ_d   = snap_cnt_q;
                        dirty_d = 1'b0;
                     end
                     default: err_d = 1'b1;
                  endcase
               end
            end
         end
         ST_SHIFT: begin
            map_d[step_dst] = map_q[sh_pos_q];
            if (sh_cnt_q == LEN_W'(1)) begin
               map_d[sh_pos_q] = EMPTY_C;
               state_d         = ST_FIN;
            end else begin
               sh_pos_d = sh_dir_q ? sh_pos_q - CW'(1) : sh_pos_q + CW'(1);
               sh_cnt_d = sh_cnt_q - LEN_W'(1);
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         // NOTE: map and snapshot are visible state, so every cell is reset, not only control.
         for (int i = 0; i < N; i++) begin
            map_q[i]  <= EMPTY_C;
            snap_q[i] <= EMPTY_C;
         end
         occ_q      <= '0;
         snap_cnt_q <= '0;
         dirty_q    <= 1'b0;
         err_q      <= 1'b0;
         rd_card_q  <= EMPTY_C;
         sh_pos_q   <= '0;
         sh_cnt_q   <= '0;
         sh_dir_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         map_q      <= map_d;
         snap_q     <= snap_d;
         occ_q      <= occ_d;
         snap_cnt_q <= snap_cnt_d;
         dirty_q    <= dirty_d;
         err_q      <= err_d;
         rd_card_q  <= rd_card_d;
         sh_pos_q   <= sh_pos_d;
         sh_cnt_q   <= sh_cnt_d;
         sh_dir_q   <= sh_dir_d;
      end
   end

   always_comb begin
      map = '0;
      for (int p = 0; p < N; p++) begin
         map[p*CARD_W +: CARD_W] = map_q[p];
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign err       = done && err_q;
   assign occ_cnt   = occ_q;
   assign dirty     = dirty_q;
   assign rd_card   = rd_card_q;

endmodule

// File: tb/tb_table_memory.sv
// Directed bench for table_memory: one instance with default geometry (A) and one
// with COLS=13, ROWS=4 (B), driven from a shared table of commands and expectations.
module tb_table_memory;

   localparam int E  = 54;
   localparam int PL = 0;
   localparam int RM = 1;
   localparam int SH = 2;
   localparam int CM = 3;
   localparam int RS = 4;
   localparam int A  = 0;
   localparam int B  = 1;

   typedef struct {
      int sel, op, x, y, card, len, dir;
      int e_err, e_lat, e_occ, e_dirty, px, py, e_cell;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, valid_a, valid_b, dir, sel;
   logic [2:0]   op, y, len;
   logic [4:0]   x;
   logic [5:0]   card;

   logic         ready_a, dirty_a, done_a, err_a;
   logic [863:0] map_a;
   logic [7:0]   occ_a;
   logic [5:0]   rd_a;
   logic         ready_b, dirty_b, done_b, err_b;
   logic [311:0] map_b;
   logic [5:0]   occ_b;
   logic [5:0]   rd_b;

   logic         ready_m, done_m, err_m, dirty_m;
   logic [7:0]   occ_m;

   int   n_checks = 0;
   int   n_errs   = 0;
   vec_t vq[$];

   table_memory u_a (
      .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_op(op),
      .cmd_x(x), .cmd_y(y), .cmd_card(card), .cmd_len(len), .cmd_dir(dir),
      .map(map_a), .occ_cnt(occ_a), .dirty(dirty_a), .done(done_a), .err(err_a),
      .rd_card(rd_a)
   );

   table_memory #(.COLS(13), .ROWS(4)) u_b (
      .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_op(op),
      .cmd_x(x[3:0]), .cmd_y(y[1:0]), .cmd_card(card), .cmd_len(len), .cmd_dir(dir),
      .map(map_b), .occ_cnt(occ_b), .dirty(dirty_b), .done(done_b), .err(err_b),
      .rd_card(rd_b)
   );

   assign ready_m = sel ? ready_b : ready_a;
   assign done_m  = sel ? done_b  : done_a;
   assign err_m   = sel ? err_b   : err_a;
   assign dirty_m = sel ? dirty_b : dirty_a;
   assign occ_m   = sel ? {2'b00, occ_b} : occ_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0] cell_of(input logic s, input int cx, input int cy);
      if (s) return map_b[(cy*13 + cx)*6 +: 6];
      return map_a[(cy*18 + cx)*6 +: 6];
   endfunction

   function automatic logic [863:0] empty_map(input logic s);
      logic [863:0] r = '0;
      for (int i = 0; i < (s ? 52 : 144); i++) r[i*6 +: 6] = 6'(E);
      return r;
   endfunction

   task automatic check_map(input string name, input logic s, input logic [863:0] exp);
      logic [863:0] act;
      int first = -1;
      act = s ? 864'(map_b) : map_a;
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         for (int i = 143; i >= 0; i--) if (act[i*6 +: 6] !== exp[i*6 +: 6]) first = i;
         $display("FAIL %s: cell %0d got %0d, expected %0d", name, first,
                  act[first*6 +: 6], exp[first*6 +: 6]);
      end
   endtask

   task automatic add(input int s, input int o, input int cx, input int cy, input int cc,
                      input int cl, input int cd, input int ee, input int el, input int eo,
                      input int ed, input int ppx, input int ppy, input int ec);
      vec_t v;
      v.sel = s; v.op = o; v.x = cx; v.y = cy; v.card = cc; v.len = cl; v.dir = cd;
      v.e_err = ee; v.e_lat = el; v.e_occ = eo; v.e_dirty = ed;
      v.px = ppx; v.py = ppy; v.e_cell = ec;
      vq.push_back(v);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issues one command on the selected instance; lat counts edges from accept to done.
   task automatic do_cmd(input vec_t v, output int lat, output int busy, output logic e);
      int  w = 0;
      bit  got = 0;
      @(negedge clk);
      while (!ready_m && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("ready before command", 32'(ready_m), 1);
      op = 3'(v.op); x = 5'(v.x); y = 3'(v.y); card = 6'(v.card); len = 3'(v.len);
      dir = (v.dir != 0);
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      lat = 0; busy = 0; e = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         if (i > 1) @(negedge clk);
         if (!ready_m) busy++;
         if (done_m) begin
            got = 1;
            lat = i;
            e   = err_m;
         end else begin
            check("err low while not done", 32'(err_m), 0);
         end
      end
      if (!got) begin
         n_checks++;
         n_errs++;
         $display("FAIL done timeout: got no done within 20 cycles, expected done");
      end
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         vec_t v;
         int   lat, busy;
         logic e;
         v   = vq[i];
         sel = v.sel[0];
         do_cmd(v, lat, busy, e);
         check($sformatf("v%0d err", i), 32'(e), v.e_err);
         check($sformatf("v%0d latency", i), lat, v.e_lat);
         check($sformatf("v%0d busy cycles", i), busy, v.e_lat);
         check($sformatf("v%0d occ_cnt", i), 32'(occ_m), v.e_occ);
         check($sformatf("v%0d dirty", i), 32'(dirty_m), v.e_dirty);
         check($sformatf("v%0d cell(%0d,%0d)", i, v.px, v.py),
               32'(cell_of(sel, v.px, v.py)), v.e_cell);
      end
   endtask

   initial begin
      logic [863:0] exp_map;
      int           dn;

      rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
      op = '0; x = '0; y = '0; card = '0; len = '0; dir = 1'b0;

      //  sel op  x  y  card len dir | err lat occ dirty | px py cell
      add(A, PL,  3, 1,  5,  0, 0,   0, 1, 1, 1,   3, 1,  5);   // 0
      add(A, PL,  3, 1,  9,  0, 0,   1, 1, 1, 1,   3, 1,  5);
      add(A, PL,  4, 0, 10,  0, 0,   0, 1, 2, 1,   4, 0, 10);
      add(A, PL,  5, 0, 11,  0, 0,   0, 1, 3, 1,   5, 0, 11);
      add(A, PL,  6, 0, 12,  0, 0,   0, 1, 4, 1,   6, 0, 12);
      add(A, SH,  4, 0,  0,  3, 1,   0, 4, 4, 1,   7, 0, 12);   // 5
      add(A, SH, 15, 0,  0,  3, 1,   1, 1, 4, 1,   7, 0, 12);
      add(A, SH,  0, 2,  0,  1, 0,   1, 1, 4, 1,  17, 1,  E);
      add(A, SH,  5, 0,  0,  0, 1,   1, 1, 4, 1,   5, 0, 10);
      add(A, PL,  0, 3,  E,  0, 0,   1, 1, 4, 1,   0, 3,  E);
      add(A, PL, 18, 0,  7,  0, 0,   1, 1, 4, 1,   0, 1,  E);   // 10
      add(A,  5,  0, 0,  7,  0, 0,   1, 1, 4, 1,   0, 0,  E);
      add(A, RM,  3, 1,  0,  0, 0,   0, 1, 3, 1,   3, 1,  E);
      add(A, RM,  3, 1,  0,  0, 0,   1, 1, 3, 1,   3, 1,  E);
      add(A, SH,  5, 0,  0,  3, 0,   0, 4, 3, 1,   4, 0, 10);
      add(A, PL,  8, 0, 20,  0, 0,   0, 1, 4, 1,   8, 0, 20);   // 15
      add(A, SH,  4, 0,  0,  4, 1,   1, 1, 4, 1,   4, 0, 10);
      add(A, SH,  8, 0,  0,  1, 0,   0, 2, 4, 1,   7, 0, 20);
      add(B, PL,  3, 1,  5,  0, 0,   0, 1, 1, 1,   3, 1,  5);
      add(B, PL,  3, 1,  5,  0, 0,   1, 1, 1, 1,   3, 1,  5);
      add(B, PL,  4, 0, 10,  0, 0,   0, 1, 2, 1,   4, 0, 10);   // 20
      add(B, PL,  5, 0, 11,  0, 0,   0, 1, 3, 1,   5, 0, 11);
      add(B, PL,  6, 0, 12,  0, 0,   0, 1, 4, 1,   6, 0, 12);
      add(B, SH,  4, 0,  0,  3, 1,   0, 4, 4, 1,   7, 0, 12);
      add(B, PL,  9, 2, 30,  0, 0,   0, 1, 5, 1,   9, 2, 30);
      add(B, PL, 10, 2, 31,  0, 0,   0, 1, 6, 1,  10, 2, 31);   // 25
      add(B, PL, 11, 2, 32,  0, 0,   0, 1, 7, 1,  11, 2, 32);
      add(B, SH, 10, 2,  0,  3, 1,   1, 1, 7, 1,  12, 2,  E);
      add(B, SH,  9, 2,  0,  3, 1,   0, 4, 7, 1,  12, 2, 32);
      add(B, PL, 13, 0,  7,  0, 0,   1, 1, 7, 1,   0, 1,  E);
      add(B, SH, 12, 2,  0,  1, 0,   1, 1, 7, 1,  12, 2, 32);   // 30
      add(A, PL,  0, 0,  1,  0, 0,   0, 1, 1, 1,   0, 0,  1);
      add(A, PL,  1, 0,  2,  0, 0,   0, 1, 2, 1,   1, 0,  2);
      add(A, PL,  2, 7,  3,  0, 0,   0, 1, 3, 1,   2, 7,  3);
      add(A, CM,  0, 0,  0,  0, 0,   0, 1, 3, 0,   0, 0,  1);
      add(A, PL, 17, 7,  4,  0, 0,   0, 1, 4, 1,  17, 7,  4);   // 35
      add(A, PL,  9, 4,  5,  0, 0,   0, 1, 5, 1,   9, 4,  5);
      add(A, RM,  0, 0,  0,  0, 0,   0, 1, 4, 1,   0, 0,  E);
      add(A, RS,  0, 0,  0,  0, 0,   0, 1, 3, 0,   0, 0,  1);
      add(A, RM,  1, 0,  0,  0, 0,   0, 1, 2, 1,   1, 0,  E);
      add(A, RS,  0, 0,  0,  0, 0,   0, 1, 3, 0,   1, 0,  2);   // 40
      add(A, PL,  4, 0, 10,  0, 0,   0, 1, 4, 1,   4, 0, 10);
      add(A, PL,  5, 0, 11,  0, 0,   0, 1, 5, 1,   5, 0, 11);
      add(A, PL,  0, 0,  7,  0, 0,   0, 1, 1, 1,   0, 0,  7);

      reset_dut();
      check("reset A ready", 32'(ready_a), 1);
      check("reset A occ", 32'(occ_a), 0);
      check("reset A dirty", 32'(dirty_a), 0);
      check("reset A done", 32'(done_a), 0);
      check("reset A err", 32'(err_a), 0);
      check("reset A rd_card", 32'(rd_a), E);
      check_map("reset A map", 1'b0, empty_map(1'b0));
      check("reset B ready", 32'(ready_b), 1);
      check("reset B occ", 32'(occ_b), 0);
      check("reset B rd_card", 32'(rd_b), E);
      check_map("reset B map", 1'b1, empty_map(1'b1));

      run_vecs(0, 6);
      check("A right shift cell 4", 32'(cell_of(0, 4, 0)), E);
      check("A right shift cell 5", 32'(cell_of(0, 5, 0)), 10);
      check("A right shift cell 6", 32'(cell_of(0, 6, 0)), 11);
      run_vecs(6, 14);
      check("A rd_card after removes", 32'(rd_a), 5);
      run_vecs(14, 15);
      check("A left shift cell 5", 32'(cell_of(0, 5, 0)), 11);
      check("A left shift cell 6", 32'(cell_of(0, 6, 0)), 12);
      check("A left shift cell 7", 32'(cell_of(0, 7, 0)), E);
      run_vecs(15, 31);
      check("B raw cell 16", 32'(map_b[96 +: 6]), 5);
      check("B right shift cell 4", 32'(cell_of(1, 4, 0)), E);
      check("B edge shift cell 9", 32'(cell_of(1, 9, 2)), E);
      check("B edge shift cell 10", 32'(cell_of(1, 10, 2)), 30);
      check("B edge shift cell 11", 32'(cell_of(1, 11, 2)), 31);
      check("B next row untouched", 32'(cell_of(1, 0, 3)), E);
      check("B rd_card untouched", 32'(rd_b), E);

      reset_dut();
      run_vecs(31, 39);
      exp_map = empty_map(1'b0);
      exp_map[(0*18 + 0)*6 +: 6] = 6'd1;
      exp_map[(0*18 + 1)*6 +: 6] = 6'd2;
      exp_map[(7*18 + 2)*6 +: 6] = 6'd3;
      check_map("A restore image", 1'b0, exp_map);
      check("A rd_card after restore", 32'(rd_a), 1);
      run_vecs(39, 43);

      // Reset lands on the second step edge of a three-cell shift.
      sel = 1'b0;
      @(negedge clk);
      check("pre-shift ready", 32'(ready_a), 1);
      op = 3'(SH); x = 5'd4; y = 3'd0; card = '0; len = 3'd3; dir = 1'b1;
      valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      check("ready low during shift", 32'(ready_a), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid-shift reset ready", 32'(ready_a), 1);
      check("mid-shift reset done", 32'(done_a), 0);
      check("mid-shift reset err", 32'(err_a), 0);
      check("mid-shift reset occ", 32'(occ_a), 0);
      check("mid-shift reset dirty", 32'(dirty_a), 0);
      check("mid-shift reset rd_card", 32'(rd_a), E);
      check_map("mid-shift reset map", 1'b0, empty_map(1'b0));
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_a) dn++;
      end
      check("done pulses after reset", dn, 0);
      run_vecs(43, 44);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test by 100000, expected earlier finish");
      $fatal(1);
   end

endmodule
